// File: rtl/imem_program_loader.sv
// Encodes LEGv8 instruction fields into 32-bit words and writes them to sequential
// instruction-memory byte addresses (0, 4, 8, ...); the exact inverse of iDecode.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_program_loader #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [1:0]                fmt,
  input  logic [10:0]               opcode,
  input  logic [4:0]                rd,
  input  logic [4:0]                rn,
  input  logic [4:0]                rm,
  input  logic [`WORD-1:0]          imm,
  output logic                      imem_we,
  output logic [`WORD-1:0]          imem_addr,
  output logic [`INSTR_LEN-1:0]     imem_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state;
  logic                  last_q;
  logic                  imm_ok;
  logic [`INSTR_LEN-1:0] word;

  // Signed ranges are checked by requiring every bit above the field to equal the field's sign.
  always_comb begin
    imm_ok = 1'b0;
    word   = '0;
    case (fmt)
      2'd0: begin
        imm_ok = (imm[`WORD-1:6] == '0);
        word   = {opcode, rm, imm[5:0], rn, rd};
      end
      2'd1: begin
        imm_ok = (&imm[`WORD-1:8]) || (~|imm[`WORD-1:8]);
        word   = {opcode, imm[8:0], 2'b00, rn, rd};
      end
      2'd2: begin
        imm_ok = (&imm[`WORD-1:18]) || (~|imm[`WORD-1:18]);
        word   = {opcode[10:3], imm[18:0], rd};
      end
      default: begin
        imm_ok = (&imm[`WORD-1:25]) || (~|imm[`WORD-1:25]);
        word   = {opcode[10:5], imm[25:0]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else if (start) begin
      // Restart wins over any pending write or simultaneous in_valid.
      state     <= LOAD;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (in_valid) begin
            if (imm_ok) begin
              imem_wdata <= word;
              imem_addr  <= `WORD'({count, 2'b00});
              last_q     <= in_last;
              imem_we    <= 1'b1;
              in_ready   <= 1'b0;
              state      <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          imem_we <= 1'b0;
          count   <= count + 1'b1;
          if (last_q || (count + 1'b1) == CW'(DEPTH)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
